// File: rtl/cdb_arbiter_if.sv
// Completion-bus arbiter port bundle: requester side and broadcast side.
// slave is the arbiter's view, master is the environment's view.
interface cdb_arbiter_if #(
    parameter int ROBsizeLog = 4
);
    logic [3:0]                 reqValid_i;
    logic [3:0][ROBsizeLog-1:0] reqTag_i;
    logic [3:0][64:0]           reqVal_i;
    logic [3:0]                 reqReady_o;
    logic                       cdbStall_i;
    logic [ROBsizeLog-1:0]      completionRSROBTag_o;
    logic [64:0]                completionRSROBval_o;
    logic                       robWriteEn_o;
    logic [1:0]                 grantIdx_o;

    modport slave (
        input  reqValid_i,
        input  reqTag_i,
        input  reqVal_i,
        input  cdbStall_i,
        output reqReady_o,
        output completionRSROBTag_o,
        output completionRSROBval_o,
        output robWriteEn_o,
        output grantIdx_o
    );

    modport master (
        output reqValid_i,
        output reqTag_i,
        output reqVal_i,
        output cdbStall_i,
        input  reqReady_o,
        input  completionRSROBTag_o,
        input  completionRSROBval_o,
        input  robWriteEn_o,
        input  grantIdx_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant over 4 result requesters.
// Define CDB_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest).
module cdb_arbiter #(
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int NUMREQ     = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    cdb_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NUMREQ);

    logic                  w_gnt;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_cand;
    logic [NUMREQ-1:0]     w_onehot;
    logic [ROBsizeLog-1:0] w_tag;
    logic                  w_bcast;

    logic                  r_wen;
    logic [ROBsizeLog-1:0] r_tag;
    logic [64:0]           r_val;
    logic [IW-1:0]         r_gidx;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
    logic [IW-1:0]         r_rrPtr;
`endif

    // Scan from the priority origin; the first valid candidate wins.
    always_comb begin
        w_gnt  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 0; k < NUMREQ; k++) begin
`ifdef CDB_ARB_FIXED_PRIORITY_EN
            w_cand = IW'(k);
`else
            w_cand = r_rrPtr + IW'(k);
`endif
            if (!w_gnt && bus.reqValid_i[w_cand]) begin
                w_gnt = 1'b1;
                w_idx = w_cand;
            end
        end
        if (reset_i || bus.cdbStall_i) begin
            w_gnt = 1'b0;
        end
    end

    always_comb begin
        w_onehot = '0;
        if (w_gnt) begin
            w_onehot[w_idx] = 1'b1;
        end
    end

    assign w_tag   = bus.reqTag_i[w_idx];
    // Tag 0 means "no ROB entry": consumed, never broadcast.
    assign w_bcast = w_gnt && (w_tag != '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wen   <= 1'b0;
            r_tag   <= '0;
            r_val   <= '0;
            r_gidx  <= '0;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
            r_rrPtr <= '0;
`endif
        end else begin
            r_wen <= w_bcast;
            if (w_bcast) begin
                r_tag  <= w_tag;
                r_val  <= bus.reqVal_i[w_idx];
                r_gidx <= w_idx;
            end
`ifndef CDB_ARB_FIXED_PRIORITY_EN
            if (w_gnt) begin
                r_rrPtr <= w_idx + IW'(1);
            end
`endif
        end
    end

    assign bus.reqReady_o           = w_onehot;
    assign bus.robWriteEn_o         = r_wen;
    assign bus.completionRSROBTag_o = r_tag;
    assign bus.completionRSROBval_o = r_val;
    assign bus.grantIdx_o           = r_gidx;

    a_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(bus.reqReady_o));
    a_stall: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.cdbStall_i |-> (bus.reqReady_o == '0));
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROBsize, default 8, number of ROB entries.
REQ-002 Parameter ROBsizeLog, default $clog2(ROBsize+1), ROB tag width; tag 0 is reserved to mean "no tag / value ready".
REQ-003 Parameter NUMREQ, fixed at 4, number of requesting functional units (one per reservation station, indexed 0-3 as whichMath).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 reqValid_i  input  [3:0]  requester g holds a completed result.
REQ-007 reqTag_i  input  [3:0][ROBsizeLog-1:0]  ROB tag of requester g's result.
REQ-008 reqVal_i  input  [3:0][64:0]  result of requester g; bit 64 is the flag bit, [63:0] is data.
REQ-009 reqReady_o  output  [3:0]  one-hot grant; requester g's result is taken this cycle.
REQ-010 cdbStall_i  input  1  the completion bus is blocked this cycle; no grant is issued.
REQ-011 completionRSROBTag_o  output  [ROBsizeLog-1:0]  registered broadcast tag.
REQ-012 completionRSROBval_o  output  [64:0]  registered broadcast value.
REQ-013 robWriteEn_o  output  1  registered broadcast valid; qualifies the tag and value for the ROB, the reservation stations and the decode bypass.
REQ-014 grantIdx_o  output  [1:0]  index of the requester that owns the current broadcast.

Function
REQ-015 Grant rule: reqReady_o is combinational. At most one bit is set. It is zero when cdbStall_i=1 or reqValid_i=0.
REQ-016 Round-robin: priority starts at pointer rrPtr and wraps 3->0. The first valid requester at or after rrPtr is granted.
REQ-017 rrPtr updates only on a cycle with a grant, to (granted index + 1) mod 4. A granted index of 3 wraps rrPtr to 0.
REQ-018 Handshake: a requester holds reqValid_i, reqTag_i and reqVal_i stable until the cycle in which its reqReady_o=1. The transfer completes in that cycle.
REQ-019 Latency: the granted tag and value appear on completionRSROBTag_o and completionRSROBval_o with robWriteEn_o=1 exactly one cycle after the grant.
REQ-020 On a cycle with no grant, robWriteEn_o=0 next cycle. The tag and value outputs keep their previous contents, and grantIdx_o holds.
REQ-021 Reserved tag: a valid request with tag 0 is granted and consumed like any other request. It is never broadcast (robWriteEn_o=0 next cycle). The pointer still advances.
REQ-022 Simultaneous requests: one winner per cycle. Each losing requester is granted within 3 further grant cycles (no starvation).
REQ-023 cdbStall_i asserted while a broadcast is in the output register does not cancel that broadcast. It only blocks the next grant.
REQ-024 No result is ever broadcast twice, and no granted result is ever lost.

Reset
REQ-025 While reset_i=1, regardless of clock: rrPtr=0, robWriteEn_o=0, completionRSROBTag_o=0, completionRSROBval_o=0, grantIdx_o=0, reqReady_o=0.
REQ-026 If reset is asserted mid-operation, any pending output-register broadcast is discarded. The first grant after reset release follows priority 0,1,2,3.

Configuration
REQ-027 Macro CDB_ARB_FIXED_PRIORITY_EN.
- Defined: rrPtr is removed and priority is fixed, requester 0 highest through 3 lowest. REQ-022 does not apply.
- Undefined: round-robin per REQ-016/017.

Verification
REQ-028 Reset, then reqValid_i=4'b1111 held with a new result loaded after each grant -> grants 0,1,2,3,0 on consecutive cycles, and robWriteEn_o=1 on the following 5 cycles.
REQ-029 Only requester 2 valid with tag 5 and value 65'h0_0000_0000_0000_002A -> reqReady_o=4'b0100; the next cycle shows completionRSROBTag_o=5, completionRSROBval_o=42, robWriteEn_o=1, grantIdx_o=2.
REQ-030 rrPtr=3 and requesters 0 and 3 valid -> requester 3 is granted, then requester 0, and rrPtr ends at 1.
REQ-031 cdbStall_i=1 for 2 cycles with all requests valid -> reqReady_o=0 and robWriteEn_o=0 for those cycles; granting resumes from the unchanged rrPtr.
REQ-032 Requester 1 valid with tag 0 -> reqReady_o[1]=1, robWriteEn_o stays 0, rrPtr becomes 2.
REQ-033 Assert reset_i between a grant and the next clock edge -> robWriteEn_o=0 immediately and the broadcast never appears; with CDB_ARB_FIXED_PRIORITY_EN defined, all valid -> requester 0 granted every cycle.
